// File: rtl/axis_stream_driver.sv
// AXI-Stream traffic source/sink: sends an arithmetic word sequence, collects returned beats and interrupt edges.
// Latency: first word valid the cycle after i_start; o_done one cycle after the completing beat is registered.
// Backpressure: o_data holds while i_data_ready is low; o_data_ready follows !i_rx_stall in every state.
module axis_stream_driver #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_words,
    input  logic [DATA_W-1:0] i_seed,
    input  logic [DATA_W-1:0] i_step,
    input  logic [CNT_W-1:0]  i_rx_expected,
    input  logic              i_rx_stall,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    input  logic              i_data_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    input  logic              i_intr,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_tx_count,
    output logic [CNT_W-1:0]  o_rx_count,
    output logic [CNT_W-1:0]  o_intr_count,
    output logic [DATA_W-1:0] o_last_rx,
    output logic              o_done,
    output logic              o_timeout
);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    rx_exp_q, rx_exp_d;
    logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]    intr_cnt_q, intr_cnt_d;
    logic [DATA_W-1:0]   last_rx_q, last_rx_d;
    logic                timeout_q, timeout_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                intr_s_q, intr_s_d;
    logic                intr_prev_q, intr_prev_d;

    logic tx_hs;
    logic rx_hs;
    logic active;
    logic intr_edge;

    assign tx_hs     = (state_q == S_SEND) && i_data_ready;
    assign rx_hs     = i_data_valid && !i_rx_stall;
    assign active    = (state_q == S_SEND) || (state_q == S_DRAIN);
    assign intr_edge = intr_s_q && !intr_prev_q;

    // Next-state and datapath updates; counters only move while a run is active.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        step_d      = step_q;
        num_d       = num_q;
        rx_exp_d    = rx_exp_q;
        tx_cnt_d    = tx_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        intr_cnt_d  = intr_cnt_q;
        last_rx_d   = last_rx_q;
        timeout_d   = timeout_q;
        idle_d      = '0;
        intr_s_d    = i_intr;
        intr_prev_d = intr_s_q;

        if (active) begin
            if (rx_hs) begin
                last_rx_d = i_data;
                if (rx_cnt_q != '1) rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
            if (intr_edge && (intr_cnt_q != '1)) intr_cnt_d = intr_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_start && (i_num_words != '0)) begin
                    num_d      = i_num_words;
                    step_d     = i_step;
                    rx_exp_d   = i_rx_expected;
                    data_d     = i_seed;
                    tx_cnt_d   = '0;
                    rx_cnt_d   = '0;
                    intr_cnt_d = '0;
                    last_rx_d  = '0;
                    timeout_d  = 1'b0;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_hs) begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                    data_d   = data_q + step_q;
                    if ((tx_cnt_q + CNT_W'(1)) == num_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Completion is judged on registered counts, so it trails the beat by one cycle.
                if (rx_cnt_q >= rx_exp_q) begin
                    state_d = S_DONE;
                end else if (idle_q == IDLE_W'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    idle_d = rx_hs ? '0 : idle_q + IDLE_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any run in progress.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            step_q      <= '0;
            num_q       <= '0;
            rx_exp_q    <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            intr_cnt_q  <= '0;
            last_rx_q   <= '0;
            timeout_q   <= 1'b0;
            idle_q      <= '0;
            intr_s_q    <= 1'b0;
            intr_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            step_q      <= step_d;
            num_q       <= num_d;
            rx_exp_q    <= rx_exp_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            intr_cnt_q  <= intr_cnt_d;
            last_rx_q   <= last_rx_d;
            timeout_q   <= timeout_d;
            idle_q      <= idle_d;
            intr_s_q    <= intr_s_d;
            intr_prev_q <= intr_prev_d;
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = (state_q == S_SEND);
    assign o_data_ready = !i_rx_stall;
    assign o_busy       = (state_q != S_IDLE);
    assign o_tx_count   = tx_cnt_q;
    assign o_rx_count   = rx_cnt_q;
    assign o_intr_count = intr_cnt_q;
    assign o_last_rx    = last_rx_q;
    assign o_done       = (state_q == S_DONE);
    assign o_timeout    = timeout_q;
endmodule

// File: tb/tb_axis_stream_driver.sv
// Self-checking bench for axis_stream_driver: table vectors, random runs, hand-written corner sequences.
// Latency: checks first-word timing, done latency and timeout latency against spec arithmetic.
// Backpressure: drives ready patterns and verifies o_data holds during stalls.
module tb_axis_stream_driver;
    localparam int TO = 20;

    logic        axi_clk = 1'b0;
    logic        axi_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_num_words = '0;
    logic [31:0] i_seed = '0;
    logic [31:0] i_step = '0;
    logic [15:0] i_rx_expected = '0;
    logic        i_rx_stall = 1'b0;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic        i_data_ready = 1'b0;
    logic [31:0] i_data_w;
    logic        i_data_valid_w;
    logic        o_data_ready;
    logic        i_intr = 1'b0;
    logic        o_busy;
    logic [15:0] o_tx_count;
    logic [15:0] o_rx_count;
    logic [15:0] o_intr_count;
    logic [31:0] o_last_rx;
    logic        o_done;
    logic        o_timeout;

    logic        loop_en = 1'b1;
    logic        lb_vld = 1'b0;
    logic [31:0] lb_dat = '0;
    logic        man_vld = 1'b0;
    logic [31:0] man_dat = '0;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [31:0] txq[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;

    assign i_data_w       = loop_en ? lb_dat : man_dat;
    assign i_data_valid_w = loop_en ? lb_vld : man_vld;

    always #5 axi_clk = ~axi_clk;

    axis_stream_driver #(.DATA_W(32), .CNT_W(16), .TIMEOUT(TO)) dut (
        .axi_clk      (axi_clk),
        .axi_reset_n  (axi_reset_n),
        .i_start      (i_start),
        .i_num_words  (i_num_words),
        .i_seed       (i_seed),
        .i_step       (i_step),
        .i_rx_expected(i_rx_expected),
        .i_rx_stall   (i_rx_stall),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .i_data       (i_data_w),
        .i_data_valid (i_data_valid_w),
        .o_data_ready (o_data_ready),
        .i_intr       (i_intr),
        .o_busy       (o_busy),
        .o_tx_count   (o_tx_count),
        .o_rx_count   (o_rx_count),
        .o_intr_count (o_intr_count),
        .o_last_rx    (o_last_rx),
        .o_done       (o_done),
        .o_timeout    (o_timeout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Loopback datapath: every accepted word comes back one cycle later.
    always @(posedge axi_clk) begin
        lb_vld <= o_data_valid && i_data_ready;
        lb_dat <= o_data;
    end

    // Monitor: record transmit handshakes, count done pulses, check hold under stall.
    always @(negedge axi_clk) begin
        if (prev_stall && o_data_valid) chk("hold_stable", {32'h0, o_data}, {32'h0, prev_dat});
        if (o_data_valid && i_data_ready) txq.push_back(o_data);
        if (o_done) done_cnt++;
        prev_stall = o_data_valid && !i_data_ready;
        prev_dat   = o_data;
    end

    typedef struct {
        logic [31:0] seed;
        logic [31:0] step;
        int          num;
        int          rxexp;
        int          mode;      // 0: ready=1, 1: 1,0,0 pattern, 2: random
        int          restart;   // pulse a second start mid-SEND
        int          intr;      // pulse i_intr three times
        int          exp_lat;   // edges from start to o_done, 0 = unchecked
        logic [31:0] exp_last;
        int          exp_intr;
    } vec_t;

    function automatic logic rdy(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 3) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int  c;
        int  lat;
        bit  seen;
        logic [31:0] expw;
        txq.delete();
        done_cnt     = 0;
        loop_en      = 1'b1;
        i_seed       = v.seed;
        i_step       = v.step;
        i_num_words  = 16'(v.num);
        i_rx_expected = 16'(v.rxexp);
        i_start      = 1'b1;
        i_data_ready = 1'b0;
        @(posedge axi_clk); #1;
        i_start = 1'b0;
        chk({tag, "_first_valid"}, {63'h0, o_data_valid}, 64'h1);
        chk({tag, "_first_data"}, {32'h0, o_data}, {32'h0, v.seed});
        c = 0; lat = 1; seen = 1'b0;
        while (!seen && lat < 400) begin
            i_data_ready = rdy(v.mode, c);
            i_intr = (v.intr != 0) && (c == 1 || c == 4 || c == 7);
            if (v.restart != 0 && c == 2) begin
                i_start = 1'b1; i_seed = 32'hDEADBEEF; i_num_words = 16'd1;
            end
            @(posedge axi_clk); #1;
            i_start = 1'b0;
            c++;
            if (o_done) seen = 1'b1;
            else lat++;
        end
        i_intr = 1'b0;
        chk({tag, "_done_seen"}, {63'h0, seen}, 64'h1);
        if (v.exp_lat != 0) chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, "_tx_hs"}, 64'(txq.size()), 64'(v.num));
        for (int i = 0; i < v.num && i < txq.size(); i++) begin
            expw = v.seed + v.step * 32'(i);
            chk({tag, "_tx_word"}, {32'h0, txq[i]}, {32'h0, expw});
        end
        chk({tag, "_tx_count"}, {48'h0, o_tx_count}, 64'(v.num));
        chk({tag, "_rx_count"}, {48'h0, o_rx_count}, 64'(v.num));
        chk({tag, "_last_rx"}, {32'h0, o_last_rx}, {32'h0, v.exp_last});
        chk({tag, "_intr_count"}, {48'h0, o_intr_count}, 64'(v.exp_intr));
        chk({tag, "_timeout"}, {63'h0, o_timeout}, 64'h0);
        @(posedge axi_clk); #1;
        chk({tag, "_idle_after"}, {63'h0, o_busy}, 64'h0);
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'h1);
    endtask

    vec_t tbl[6];
    vec_t rv;
    int   lat;
    bit   seen;

    initial begin
        tbl[0] = '{32'h10,       32'h1,   4, 4, 0, 0, 0, 6, 32'h13,   0};
        tbl[1] = '{32'hA0,       32'h5,   3, 3, 1, 0, 0, 0, 32'hAA,   0};
        tbl[2] = '{32'hFFFFFFFE, 32'h1,   3, 3, 0, 0, 0, 5, 32'h0,    0};
        tbl[3] = '{32'h1000,     32'h100, 6, 6, 1, 1, 0, 0, 32'h1500, 0};
        tbl[4] = '{32'h7,        32'h3,  10, 10, 1, 0, 1, 0, 32'h22,  3};
        tbl[5] = '{32'h55,       32'h2,   3, 0, 0, 0, 0, 4, 32'h59,   0};

        // Reset state
        i_rx_stall = 1'b1;
        #12;
        chk("rst_valid", {63'h0, o_data_valid}, 64'h0);
        chk("rst_busy", {63'h0, o_busy}, 64'h0);
        chk("rst_data", {32'h0, o_data}, 64'h0);
        chk("rst_counts", {o_tx_count, o_rx_count, o_intr_count, 16'h0}, 64'h0);
        chk("rst_done_to", {62'h0, o_done, o_timeout}, 64'h0);
        chk("rst_ready_stall", {63'h0, o_data_ready}, 64'h0);
        i_rx_stall = 1'b0;
        #1;
        chk("rst_ready_nostall", {63'h0, o_data_ready}, 64'h1);
        axi_reset_n = 1'b1;
        @(posedge axi_clk); #1;

        // Start with zero words is ignored
        i_num_words = 16'd0; i_start = 1'b1;
        @(posedge axi_clk); #1;
        i_start = 1'b0;
        chk("zero_start_busy", {63'h0, o_busy}, 64'h0);
        chk("zero_start_valid", {63'h0, o_data_valid}, 64'h0);

        // Timeout: two beats returned during SEND, then silence in DRAIN
        loop_en = 1'b0; man_vld = 1'b1; man_dat = 32'hBEEF0001;
        i_data_ready = 1'b1; i_seed = 32'h40; i_step = 32'h1;
        i_num_words = 16'd2; i_rx_expected = 16'd5; i_start = 1'b1;
        @(posedge axi_clk); #1;
        i_start = 1'b0;
        @(posedge axi_clk); #1;
        man_dat = 32'hBEEF0002;
        @(posedge axi_clk); #1;
        man_vld = 1'b0;
        chk("to_drain_valid", {63'h0, o_data_valid}, 64'h0);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 3 * TO) begin
            @(posedge axi_clk); #1;
            lat++;
            if (o_done) seen = 1'b1;
        end
        chk("to_latency", 64'(lat), 64'(TO + 1));
        chk("to_flag", {63'h0, o_timeout}, 64'h1);
        chk("to_rx_count", {48'h0, o_rx_count}, 64'h2);
        chk("to_last_rx", {32'h0, o_last_rx}, 64'hBEEF0002);
        @(posedge axi_clk); #1;
        chk("to_sticky", {63'h0, o_timeout}, 64'h1);
        loop_en = 1'b1;

        // Table-driven runs
        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Randomized runs against the arithmetic model
        for (int r = 0; r < 10; r++) begin
            rv.seed     = $urandom;
            rv.step     = $urandom;
            rv.num      = $urandom_range(1, 12);
            rv.rxexp    = $urandom_range(0, rv.num);
            rv.mode     = 2;
            rv.restart  = 0;
            rv.intr     = 0;
            rv.exp_lat  = 0;
            rv.exp_last = rv.seed + rv.step * 32'(rv.num - 1);
            rv.exp_intr = 0;
            run_vec(rv, $sformatf("rnd%0d", r));
        end

        // Reset after two of eight words
        done_cnt = 0;
        i_seed = 32'h300; i_step = 32'h1; i_num_words = 16'd8; i_rx_expected = 16'd8;
        i_data_ready = 1'b1; i_start = 1'b1;
        @(posedge axi_clk); #1;
        i_start = 1'b0;
        @(posedge axi_clk); #1;
        @(posedge axi_clk); #1;
        chk("mid_tx_count", {48'h0, o_tx_count}, 64'h2);
        axi_reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'h0, o_data_valid}, 64'h0);
        chk("mid_rst_counts", {o_tx_count, o_rx_count, o_intr_count, 16'h0}, 64'h0);
        chk("mid_rst_busy", {63'h0, o_busy}, 64'h0);
        #2;
        axi_reset_n = 1'b1;
        repeat (30) @(posedge axi_clk);
        #1;
        chk("mid_rst_no_done", 64'(done_cnt), 64'h0);
        chk("mid_rst_stays_idle", {62'h0, o_busy, o_data_valid}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
